dmi_jtag_cdc_req_sync: RTL and testbench
========================================

Name: dmi_jtag_cdc_req_sync

Overview:
- Parametrised multi-channel JTAG(TCK)-to-core(clk) request synchroniser for the DMI path.
- Each channel: level input from TCK domain -> SYNC_STAGES flop chain -> edge detect -> pending register held until core handshake.
- Adds per-channel valid/ready handshake, configurable edge polarity, and sticky overrun flags.
- Keeps reg_en/reg_wr_en outputs so it drops into the existing DMI wrapper.

Parameters:
- NUM_CH, 2, number of request channels (1..16).
- SYNC_STAGES, 2, synchroniser depth (2..4).
- EDGE_MODE, 0, edge that counts as an event: 0 rising, 1 falling, 2 both.
- WR_CH, 0, channel index that drives reg_wr_en.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_in  in  NUM_CH  TCK-domain level requests, async to clk.
- ch_ready  in  NUM_CH  core accepts the event on that channel.
- ovr_clr  in  NUM_CH  clear mask for overrun flags.
- ch_valid  out  NUM_CH  event pending on that channel.
- ch_overrun  out  NUM_CH  sticky: an event was merged while pending.
- reg_en  out  1  OR of all ch_valid bits.
- reg_wr_en  out  1  ch_valid[WR_CH].
- ovr_cnt  out  8*NUM_CH  per-channel overrun counts (see Optional Feature).

Behaviour:
- Reset: clk is the only clock and rst_n is the only reset; rst_n is asynchronous, active-low. All sync flops, history flop, pending and overrun registers clear to 0, so every output is 0 during reset.
- Per channel:
  - Chain s[0..SYNC_STAGES-1] shifts req_in each clk; h <= s[last].
  - edge = s[last]&~h (rise), ~s[last]&h (fall), s[last]^h (both).
  - Edge detect is combinational; pending (ch_valid) is registered.
- Latency: req_in change captured at edge 1 -> ch_valid high after edge SYNC_STAGES+1 (3 clks at default).
- Handshake: event consumed on a clk edge where ch_valid & ch_ready. ch_ready without ch_valid has no effect.
- Pending next-state:
  - edge -> 1.
  - else valid&ready -> 0.
  - else hold.
- Simultaneous edge and consume in one cycle: pending stays 1 (new event), no overrun.
- Edge while pending and not consumed: pending stays 1 (events merge) and ch_overrun sets.
- ovr_clr clears ch_overrun; a set in the same cycle wins.
- Input held high through reset release: rising edge detected after SYNC_STAGES+1 clks. This is intended and matches the current DMI wrapper.
- Input pulse narrower than one clk period: may be missed. The TCK side must hold levels at least SYNC_STAGES+1 clk periods.
- Channels are fully independent; there is no arbitration. reg_en/reg_wr_en are pure combinational decodes of ch_valid.
- No combinational path from req_in to any output.

Optional Feature:
- Macro DMI_SYNC_OVR_CNT_EN.
- Defined:
  - Per-channel 8-bit saturating counter increments on each overrun event and holds at 255.
  - Cleared by the channel's ovr_clr bit; an increment in the same cycle wins, giving count 1.
  - Reset 0.
- Undefined: ovr_cnt is driven constant 0 and no counter flops exist.

Decomposition:
- Package dmi_sync_pkg:
  - EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2.
  - OVR_CNT_W=8, OVR_CNT_MAX=255.
  - Parameter range checks, as elaboration-time asserts.
- Sub-module dmi_sync_bit:
  - One channel: chain, history, edge detect, pending, overrun, optional counter.
  - The top generates NUM_CH instances and builds the reg_en/reg_wr_en decodes.

Test Plan:
- Reset values: assert rst_n low mid-traffic -> all outputs 0 immediately.
- Latency: after reset, req_in[0] 0->1 with ch_ready=1 -> ch_valid[0]=1 for exactly 1 clk, 3 clks after capture; reg_wr_en=1 and reg_en=1 in that cycle.
- Backpressure and overrun: ch_ready=0; toggle req_in[1] 0->1->0->1, EDGE_MODE=0 -> ch_valid[1] held, ch_overrun[1]=1 after second rise; ch_ready pulse -> ch_valid[1]=0; ovr_clr[1] -> ch_overrun[1]=0.
- Edge and consume coincide: rising edge in the cycle where ch_valid&ch_ready -> ch_valid stays 1, no overrun; next ready clears it.
- Edge modes: EDGE_MODE=2 with input 0->1->0 -> two events; EDGE_MODE=1 -> one event on the fall only.
- Overrun counter: with DMI_SYNC_OVR_CNT_EN, 300 overruns -> ovr_cnt=255; ovr_clr -> 0. Without the macro -> ovr_cnt stays 0.

Source files
------------

// File: rtl/dmi_sync_pkg.sv
// Shared constants and parameter validation for the DMI request synchroniser.
package dmi_sync_pkg;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  localparam int unsigned OVR_CNT_W = 8;
  localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = 8'd255;

  function automatic bit sync_params_ok(input int unsigned num_ch,
                                        input int unsigned sync_stages,
                                        input int unsigned edge_mode,
                                        input int unsigned wr_ch);
    return (num_ch >= 1) && (num_ch <= 16) &&
           (sync_stages >= 2) && (sync_stages <= 4) &&
           (edge_mode <= EDGE_BOTH) && (wr_ch < num_ch);
  endfunction

endpackage

// File: rtl/dmi_sync_bit.sv
// One request channel: sync chain, edge detect, pending/overrun state.
// Optional saturating overrun counter enabled by DMI_SYNC_OVR_CNT_EN.
module dmi_sync_bit
  import dmi_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_in,
  input  logic                 ch_ready,
  input  logic                 ovr_clr,
  output logic                 ch_valid,
  output logic                 ch_overrun,
  output logic [OVR_CNT_W-1:0] ovr_cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_last;
  logic                   edge_det;
  logic                   pend_q, pend_d;
  logic                   ovr_q, ovr_d;
  logic                   ovr_set;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_det = 1'b0;
    case (EDGE_MODE)
      EDGE_FALL: edge_det = ~sync_last & hist_q;
      EDGE_BOTH: edge_det = sync_last ^ hist_q;
      default:   edge_det = sync_last & ~hist_q;
    endcase
  end

  // An edge landing on an unconsumed event merges into it and flags overrun.
  always_comb begin
    ovr_set = edge_det & pend_q & ~ch_ready;
    pend_d  = pend_q;
    if (edge_det) begin
      pend_d = 1'b1;
    end else if (pend_q && ch_ready) begin
      pend_d = 1'b0;
    end
    ovr_d = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
      hist_q <= sync_last;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign ch_valid   = pend_q;
  assign ch_overrun = ovr_q;

`ifdef DMI_SYNC_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ovr_set) begin
      if (ovr_clr) begin
        cnt_d = OVR_CNT_W'(1);
      end else if (cnt_q != OVR_CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (ovr_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovr_cnt = cnt_q;
`else
  assign ovr_cnt = '0;
`endif

endmodule

// File: rtl/dmi_jtag_cdc_req_sync.sv
// Multi-channel TCK-to-core request synchroniser with valid/ready handshake.
// Optional per-channel overrun counters enabled by DMI_SYNC_OVR_CNT_EN.
module dmi_jtag_cdc_req_sync
  import dmi_sync_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = EDGE_RISE,
  parameter int unsigned WR_CH       = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           req_in,
  input  logic [NUM_CH-1:0]           ch_ready,
  input  logic [NUM_CH-1:0]           ovr_clr,
  output logic [NUM_CH-1:0]           ch_valid,
  output logic [NUM_CH-1:0]           ch_overrun,
  output logic                        reg_en,
  output logic                        reg_wr_en,
  output logic [OVR_CNT_W*NUM_CH-1:0] ovr_cnt
);

  if (!sync_params_ok(NUM_CH, SYNC_STAGES, EDGE_MODE, WR_CH)) begin : g_param_err
    $fatal(1, "dmi_jtag_cdc_req_sync: parameter out of range");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dmi_sync_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
    ) u_bit (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_in     (req_in[i]),
      .ch_ready   (ch_ready[i]),
      .ovr_clr    (ovr_clr[i]),
      .ch_valid   (ch_valid[i]),
      .ch_overrun (ch_overrun[i]),
      .ovr_cnt    (ovr_cnt[i*OVR_CNT_W +: OVR_CNT_W])
    );
  end

  assign reg_en    = |ch_valid;
  assign reg_wr_en = ch_valid[WR_CH];

endmodule

// File: tb/tb_dmi_jtag_cdc_req_sync.sv
// Directed bench for dmi_jtag_cdc_req_sync: latency, handshake, overrun, edge modes.
module tb_dmi_jtag_cdc_req_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_in, ch_ready, ovr_clr;
  logic [1:0]  ch_valid, ch_overrun;
  logic        reg_en, reg_wr_en;
  logic [15:0] ovr_cnt;

  // Single-channel instances for the falling and both-edge modes.
  logic       req_aux;
  logic       rdy_aux = 1'b1;
  logic       clr_aux = 1'b0;
  logic       v_fall, o_fall, re_fall, rw_fall;
  logic       v_both, o_both, re_both, rw_both;
  logic [7:0] c_fall, c_both;
  int         n_fall = 0;
  int         n_both = 0;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DMI_SYNC_OVR_CNT_EN
  localparam logic [7:0] CntOne = 8'd1;
  localparam logic [7:0] CntSat = 8'd255;
`else
  localparam logic [7:0] CntOne = 8'd0;
  localparam logic [7:0] CntSat = 8'd0;
`endif

  always #5 clk = ~clk;

  dmi_jtag_cdc_req_sync #(.NUM_CH(2), .SYNC_STAGES(2), .EDGE_MODE(0), .WR_CH(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .ch_ready(ch_ready), .ovr_clr(ovr_clr),
    .ch_valid(ch_valid), .ch_overrun(ch_overrun), .reg_en(reg_en), .reg_wr_en(reg_wr_en),
    .ovr_cnt(ovr_cnt)
  );

  dmi_jtag_cdc_req_sync #(.NUM_CH(1), .SYNC_STAGES(2), .EDGE_MODE(1), .WR_CH(0)) dut_fall (
    .clk(clk), .rst_n(rst_n), .req_in(req_aux), .ch_ready(rdy_aux), .ovr_clr(clr_aux),
    .ch_valid(v_fall), .ch_overrun(o_fall), .reg_en(re_fall), .reg_wr_en(rw_fall),
    .ovr_cnt(c_fall)
  );

  dmi_jtag_cdc_req_sync #(.NUM_CH(1), .SYNC_STAGES(2), .EDGE_MODE(2), .WR_CH(0)) dut_both (
    .clk(clk), .rst_n(rst_n), .req_in(req_aux), .ch_ready(rdy_aux), .ovr_clr(clr_aux),
    .ch_valid(v_both), .ch_overrun(o_both), .reg_en(re_both), .reg_wr_en(rw_both),
    .ovr_cnt(c_both)
  );

  // With ready tied high each valid cycle is one consumed event.
  always @(posedge clk) begin
    if (rst_n && v_fall) n_fall <= n_fall + 1;
    if (rst_n && v_both) n_both <= n_both + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req_in   = 2'b00;
    ch_ready = 2'b00;
    ovr_clr  = 2'b00;
    req_aux  = 1'b0;
    #1;
    chk("rst_valid_async", 32'(ch_valid), 32'h0);
    tick(2);
    chk("rst_valid", 32'(ch_valid), 32'h0);
    chk("rst_overrun", 32'(ch_overrun), 32'h0);
    chk("rst_reg_en", 32'(reg_en), 32'h0);
    chk("rst_reg_wr_en", 32'(reg_wr_en), 32'h0);
    chk("rst_ovr_cnt", 32'(ovr_cnt), 32'h0);
    rst_n = 1'b1;

    // Latency: event visible after the third edge, consumed on the fourth.
    ch_ready = 2'b01;
    req_in   = 2'b01;
    tick(1);
    chk("lat_edge1", 32'(ch_valid), 32'h0);
    tick(1);
    chk("lat_edge2", 32'(ch_valid), 32'h0);
    tick(1);
    chk("lat_edge3_valid", 32'(ch_valid), 32'h1);
    chk("lat_reg_en", 32'(reg_en), 32'h1);
    chk("lat_reg_wr_en", 32'(reg_wr_en), 32'h1);
    tick(1);
    chk("lat_consumed", 32'(ch_valid), 32'h0);
    req_in = 2'b00;
    tick(4);
    chk("rise_mode_no_fall_event", 32'(ch_valid), 32'h0);

    // Backpressure and overrun on channel 1.
    req_in[1] = 1'b1;
    tick(3);
    chk("bp_valid", 32'(ch_valid), 32'h2);
    chk("bp_reg_en", 32'(reg_en), 32'h1);
    chk("bp_reg_wr_en", 32'(reg_wr_en), 32'h0);
    chk("bp_no_overrun", 32'(ch_overrun), 32'h0);
    req_in[1] = 1'b0;
    tick(2);
    req_in[1] = 1'b1;
    tick(3);
    chk("bp_overrun_set", 32'(ch_overrun), 32'h2);
    chk("bp_valid_held", 32'(ch_valid), 32'h2);
    chk("bp_cnt_one", 32'(ovr_cnt), {16'h0, CntOne, 8'h0});
    ch_ready[1] = 1'b1;
    tick(1);
    chk("bp_consumed", 32'(ch_valid), 32'h0);
    ch_ready[1] = 1'b0;
    chk("bp_overrun_sticky", 32'(ch_overrun), 32'h2);
    ovr_clr = 2'b10;
    tick(1);
    ovr_clr = 2'b00;
    chk("bp_overrun_clr", 32'(ch_overrun), 32'h0);
    chk("bp_cnt_clr", 32'(ovr_cnt), 32'h0);

    // Edge coinciding with consume keeps the event without overrun.
    req_in[1] = 1'b0;
    tick(3);
    req_in[1] = 1'b1;
    tick(3);
    chk("co_valid", 32'(ch_valid), 32'h2);
    req_in[1] = 1'b0;
    tick(3);
    req_in[1] = 1'b1;
    tick(2);
    ch_ready[1] = 1'b1;
    tick(1);
    chk("co_valid_kept", 32'(ch_valid), 32'h2);
    chk("co_no_overrun", 32'(ch_overrun), 32'h0);
    tick(1);
    chk("co_next_consume", 32'(ch_valid), 32'h0);
    ch_ready[1] = 1'b0;

    // Reset mid-traffic, then input held high through reset release.
    req_in[1] = 1'b0;
    tick(3);
    req_in[1] = 1'b1;
    tick(3);
    chk("mid_pending", 32'(ch_valid), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ch_valid), 32'h0);
    chk("mid_rst_reg_en", 32'(reg_en), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("held_edge2", 32'(ch_valid), 32'h0);
    tick(1);
    chk("held_edge3", 32'(ch_valid), 32'h2);

    // 300 overruns on channel 1 while its event stays pending.
    for (int i = 0; i < 300; i++) begin
      req_in[1] = 1'b0;
      tick(1);
      req_in[1] = 1'b1;
      tick(1);
    end
    tick(3);
    chk("cnt_sat", 32'(ovr_cnt), {16'h0, CntSat, 8'h0});
    chk("cnt_overrun", 32'(ch_overrun), 32'h2);
    ovr_clr = 2'b10;
    tick(1);
    ovr_clr = 2'b00;
    chk("cnt_clr", 32'(ovr_cnt), 32'h0);
    chk("cnt_overrun_clr", 32'(ch_overrun), 32'h0);

    // Falling and both-edge instances.
    req_aux = 1'b1;
    tick(6);
    chk("both_rise", 32'(n_both), 32'd1);
    chk("fall_rise", 32'(n_fall), 32'd0);
    req_aux = 1'b0;
    tick(6);
    chk("both_fall", 32'(n_both), 32'd2);
    chk("fall_fall", 32'(n_fall), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
